// File: rtl/eh2_lsu_addrchk_arb.sv
// Shares one LSU address-check pipeline (dc1/dc2) between two threads and DMA,
// and returns each request's fault result, in accept order, on a valid/ready response channel.
module eh2_lsu_addrchk_arb #(
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 7
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [1:0]         t_req_valid,
  input  logic [63:0]        t_req_addr,
  input  logic [3:0]         t_req_size,
  input  logic [2*TAG_W-1:0] t_req_tag,
  output logic [1:0]         t_req_ready,
  input  logic               dma_req_valid,
  input  logic [31:0]        dma_req_addr,
  input  logic [1:0]         dma_req_size,
  input  logic [TAG_W-1:0]   dma_req_tag,
  output logic               dma_req_ready,
  input  logic [1:0]         flush,
  output logic               chk_valid_dc1,
  output logic               chk_valid_dc2,
  output logic [31:0]        chk_start_addr_dc1,
  output logic [31:0]        chk_end_addr_dc1,
  output logic [31:0]        chk_start_addr_dc2,
  output logic [31:0]        chk_end_addr_dc2,
  output logic               chk_by_dc2,
  output logic               chk_half_dc2,
  output logic               chk_word_dc2,
  output logic               chk_dma_dc2,
  input  logic               chk_access_fault_dc2,
  input  logic               chk_misaligned_fault_dc2,
  input  logic [3:0]         chk_mscause_dc2,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_tid,
  output logic               rsp_dma,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [1:0]         rsp_exc,
  output logic [3:0]         rsp_mscause,
  output logic               busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic [31:0] end_addr(input logic [31:0] start, input logic [1:0] size);
    logic [1:0] lg;
    lg = (size == 2'd3) ? 2'd2 : size;
    return start + ((32'd1 << lg) - 32'd1);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= LIMIT) ? cnt : cnt + 4'd1;
  endfunction

  function automatic logic [1:0] exc_code(input logic mis, input logic acc);
    return mis ? 2'd2 : (acc ? 2'd1 : 2'd0);
  endfunction

  logic             vld_p0, vld_p1, vld_p2;
  logic             tid_p0, tid_p1, tid_p2;
  logic             dma_p0, dma_p1, dma_p2;
  logic [31:0]      addr_p0, start_p1, end_p1;
  logic [1:0]       size_p0, size_p1;
  logic [TAG_W-1:0] tag_p0, tag_p1, tag_p2;
  logic [1:0]       exc_p2;
  logic [3:0]       msc_p2;
  logic             rr_ptr;
  logic [3:0]       starve_cnt;

  logic             live_p0, live_p1, live_p2;
  logic             free_p0, free_p1, free_p2;
  logic [1:0]       t_elig;
  logic             t_pend, acc_en, gnt_dma, gnt_thr, gnt_tid;
  logic [31:0]      req_addr;
  logic [1:0]       req_size;
  logic [TAG_W-1:0] req_tag;

  // A flushed entry still occupies its slot this cycle; only its valid is dropped.
  always_comb begin
    live_p0 = vld_p0 & ~(~dma_p0 & flush[tid_p0]);
    live_p1 = vld_p1 & ~(~dma_p1 & flush[tid_p1]);
    live_p2 = vld_p2 & ~(~dma_p2 & flush[tid_p2]);
    free_p2 = ~vld_p2 | rsp_ready;
    free_p1 = ~vld_p1 | free_p2;
    free_p0 = ~vld_p0 | free_p1;
  end

  always_comb begin
    t_elig  = t_req_valid & ~flush;
    t_pend  = |t_elig;
    acc_en  = rst_l & free_p0;
    gnt_dma = acc_en & dma_req_valid & ~((starve_cnt == LIMIT) & t_pend);
    gnt_thr = acc_en & ~gnt_dma & t_pend;
    gnt_tid = t_elig[rr_ptr] ? rr_ptr : ~rr_ptr;
    t_req_ready   = gnt_thr ? (gnt_tid ? 2'b10 : 2'b01) : 2'b00;
    dma_req_ready = gnt_dma;
    req_addr = dma_req_addr;
    req_size = dma_req_size;
    req_tag  = dma_req_tag;
    if (!gnt_dma) begin
      req_addr = gnt_tid ? t_req_addr[63:32] : t_req_addr[31:0];
      req_size = gnt_tid ? t_req_size[3:2] : t_req_size[1:0];
      req_tag  = gnt_tid ? t_req_tag[2*TAG_W-1:TAG_W] : t_req_tag[TAG_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      rr_ptr     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      vld_p0 <= free_p0 ? (gnt_dma | gnt_thr) : live_p0;
      vld_p1 <= free_p1 ? live_p0 : live_p1;
      vld_p2 <= free_p2 ? live_p1 : live_p2;
      if (gnt_thr)
        rr_ptr <= ~rr_ptr;
      if (!t_pend || gnt_thr)
        starve_cnt <= '0;
      else if (gnt_dma)
        starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Stage A (dc1) load
  always_ff @(posedge clk) begin
    if (free_p0) begin
      tid_p0  <= gnt_dma ? 1'b0 : gnt_tid;
      dma_p0  <= gnt_dma;
      addr_p0 <= req_addr;
      size_p0 <= req_size;
      tag_p0  <= req_tag;
    end
  end

  // Stage B (dc2) load
  always_ff @(posedge clk) begin
    if (free_p1) begin
      tid_p1   <= tid_p0;
      dma_p1   <= dma_p0;
      start_p1 <= addr_p0;
      end_p1   <= end_addr(addr_p0, size_p0);
      size_p1  <= size_p0;
      tag_p1   <= tag_p0;
    end
  end

  // Stage R (response) load, fault capture
  always_ff @(posedge clk) begin
    if (free_p2) begin
      tid_p2 <= tid_p1;
      dma_p2 <= dma_p1;
      tag_p2 <= tag_p1;
      exc_p2 <= exc_code(chk_misaligned_fault_dc2, chk_access_fault_dc2);
      msc_p2 <= (chk_misaligned_fault_dc2 | chk_access_fault_dc2) ? chk_mscause_dc2 : 4'd0;
    end
  end

  assign chk_valid_dc1      = vld_p0;
  assign chk_start_addr_dc1 = addr_p0;
  assign chk_end_addr_dc1   = end_addr(addr_p0, size_p0);
  assign chk_valid_dc2      = vld_p1;
  assign chk_start_addr_dc2 = start_p1;
  assign chk_end_addr_dc2   = end_p1;
  assign chk_by_dc2         = (size_p1 == 2'd0);
  assign chk_half_dc2       = (size_p1 == 2'd1);
  assign chk_word_dc2       = size_p1[1];
  assign chk_dma_dc2        = dma_p1;
  assign rsp_valid          = vld_p2;
  assign rsp_tid            = tid_p2;
  assign rsp_dma            = dma_p2;
  assign rsp_tag            = tag_p2;
  assign rsp_exc            = exc_p2;
  assign rsp_mscause        = vld_p2 ? msc_p2 : 4'd0;
  assign busy               = vld_p0 | vld_p1 | vld_p2;

endmodule

// File: tb/tb_eh2_lsu_addrchk_arb.sv
// Bench for eh2_lsu_addrchk_arb: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_eh2_lsu_addrchk_arb;
  localparam int TAG_W = 4;
  localparam int LIM   = 7;

  logic clk, rst_l;
  logic [1:0] t_req_valid, t_req_ready, flush;
  logic [63:0] t_req_addr;
  logic [3:0] t_req_size;
  logic [2*TAG_W-1:0] t_req_tag;
  logic dma_req_valid, dma_req_ready;
  logic [31:0] dma_req_addr;
  logic [1:0] dma_req_size;
  logic [TAG_W-1:0] dma_req_tag;
  logic chk_valid_dc1, chk_valid_dc2;
  logic [31:0] chk_start_addr_dc1, chk_end_addr_dc1, chk_start_addr_dc2, chk_end_addr_dc2;
  logic chk_by_dc2, chk_half_dc2, chk_word_dc2, chk_dma_dc2;
  logic chk_access_fault_dc2, chk_misaligned_fault_dc2;
  logic [3:0] chk_mscause_dc2;
  logic rsp_valid, rsp_ready, rsp_tid, rsp_dma, busy;
  logic [TAG_W-1:0] rsp_tag;
  logic [1:0] rsp_exc;
  logic [3:0] rsp_mscause;

  eh2_lsu_addrchk_arb #(.TAG_W(TAG_W), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_l(rst_l),
    .t_req_valid(t_req_valid), .t_req_addr(t_req_addr), .t_req_size(t_req_size),
    .t_req_tag(t_req_tag), .t_req_ready(t_req_ready),
    .dma_req_valid(dma_req_valid), .dma_req_addr(dma_req_addr), .dma_req_size(dma_req_size),
    .dma_req_tag(dma_req_tag), .dma_req_ready(dma_req_ready),
    .flush(flush),
    .chk_valid_dc1(chk_valid_dc1), .chk_valid_dc2(chk_valid_dc2),
    .chk_start_addr_dc1(chk_start_addr_dc1), .chk_end_addr_dc1(chk_end_addr_dc1),
    .chk_start_addr_dc2(chk_start_addr_dc2), .chk_end_addr_dc2(chk_end_addr_dc2),
    .chk_by_dc2(chk_by_dc2), .chk_half_dc2(chk_half_dc2), .chk_word_dc2(chk_word_dc2),
    .chk_dma_dc2(chk_dma_dc2),
    .chk_access_fault_dc2(chk_access_fault_dc2), .chk_misaligned_fault_dc2(chk_misaligned_fault_dc2),
    .chk_mscause_dc2(chk_mscause_dc2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tid(rsp_tid), .rsp_dma(rsp_dma),
    .rsp_tag(rsp_tag), .rsp_exc(rsp_exc), .rsp_mscause(rsp_mscause), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic tid;
    logic dma;
    logic [TAG_W-1:0] tag;
    logic [31:0] addr;
    logic [1:0] size;
    int stage;           // 0 = dc1, 1 = dc2, 2 = response
    logic [1:0] exc;
    logic [3:0] msc;
  } ent_t;

  ent_t q[$];             // oldest first
  bit   mptr;
  int   mcnt;
  logic e_gd, e_gt, e_gtid;

  function automatic logic [31:0] m_end(input logic [31:0] a, input logic [1:0] s);
    int bytes;
    bytes = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    return a + 32'(bytes - 1);
  endfunction

  task automatic calc();
    logic [1:0] elig;
    logic pend, room;
    elig = t_req_valid & ~flush;
    pend = |elig;
    room = rst_l && (q.size() < 3 || rsp_ready);
    e_gd = room && dma_req_valid && !(mcnt == LIM && pend);
    e_gt = room && !e_gd && pend;
    e_gtid = elig[mptr] ? mptr : !mptr;
  endtask

  task automatic step();
    int nt;
    ent_t n;
    logic pend;
    calc();
    pend = |(t_req_valid & ~flush);
    if (q.size() > 0 && q[0].stage == 2 && rsp_ready) q.delete(0);
    for (int i = 0; i < q.size(); i++) begin
      nt = q[i].stage + 1;
      if (nt <= 2 && (i == 0 || q[i-1].stage != nt)) begin
        q[i].stage = nt;
        if (nt == 2) begin
          q[i].exc = chk_misaligned_fault_dc2 ? 2'd2 : chk_access_fault_dc2 ? 2'd1 : 2'd0;
          q[i].msc = (q[i].exc != 0) ? chk_mscause_dc2 : 4'd0;
        end
      end
    end
    if (e_gd || e_gt) begin
      n.dma = e_gd;
      n.tid = e_gd ? 1'b0 : e_gtid;
      n.tag = e_gd ? dma_req_tag : (e_gtid ? t_req_tag[7:4] : t_req_tag[3:0]);
      n.addr = e_gd ? dma_req_addr : (e_gtid ? t_req_addr[63:32] : t_req_addr[31:0]);
      n.size = e_gd ? dma_req_size : (e_gtid ? t_req_size[3:2] : t_req_size[1:0]);
      n.stage = 0; n.exc = 0; n.msc = 0;
      q.push_back(n);
    end
    for (int i = q.size() - 1; i >= 0; i--)
      if (!q[i].dma && flush[q[i].tid]) q.delete(i);
    if (e_gt) begin mptr = !mptr; mcnt = 0; end
    else if (!pend) mcnt = 0;
    else if (e_gd && mcnt < LIM) mcnt++;
  endtask

  task automatic compare();
    int i0, i1, i2;
    logic [1:0] sz;
    calc();
    i0 = -1; i1 = -1; i2 = -1;
    foreach (q[i]) begin
      if (q[i].stage == 0) i0 = i;
      if (q[i].stage == 1) i1 = i;
      if (q[i].stage == 2) i2 = i;
    end
    chk("t_req_ready", t_req_ready, e_gt ? (e_gtid ? 2 : 1) : 0);
    chk("dma_req_ready", dma_req_ready, e_gd);
    chk("busy", busy, q.size() > 0);
    chk("chk_valid_dc1", chk_valid_dc1, i0 >= 0);
    if (i0 >= 0) begin
      chk("start_dc1", chk_start_addr_dc1, q[i0].addr);
      chk("end_dc1", chk_end_addr_dc1, m_end(q[i0].addr, q[i0].size));
    end
    chk("chk_valid_dc2", chk_valid_dc2, i1 >= 0);
    if (i1 >= 0) begin
      sz = q[i1].size;
      chk("start_dc2", chk_start_addr_dc2, q[i1].addr);
      chk("end_dc2", chk_end_addr_dc2, m_end(q[i1].addr, sz));
      chk("qual_dc2", {chk_by_dc2, chk_half_dc2, chk_word_dc2, chk_dma_dc2},
          {sz == 0, sz == 1, sz >= 2, q[i1].dma});
    end
    chk("rsp_valid", rsp_valid, i2 >= 0);
    chk("rsp_mscause", rsp_mscause, (i2 >= 0) ? q[i2].msc : 4'd0);
    if (i2 >= 0)
      chk("rsp_payload", {rsp_tid, rsp_dma, rsp_tag, rsp_exc},
          {q[i2].tid, q[i2].dma, q[i2].tag, q[i2].exc});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_l) compare();
      @(posedge clk);
      if (!rst_l) begin q.delete(); mptr = 0; mcnt = 0; end
      else step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    t_req_valid = 0; t_req_addr = 0; t_req_size = 0; t_req_tag = 0;
    dma_req_valid = 0; dma_req_addr = 0; dma_req_size = 0; dma_req_tag = 0;
    flush = 0; rsp_ready = 1;
    chk_access_fault_dc2 = 0; chk_misaligned_fault_dc2 = 0; chk_mscause_dc2 = 0;
  endtask

  task automatic do_reset();
    rst_l = 0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_l = 1;
  endtask

  initial begin
    rst_l = 0;
    idle();
    do_reset();

    // reset state
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_dc1", chk_valid_dc1, 0);
    tick();

    // starvation limit: 7 DMA grants then thread 0, repeating
    dma_req_valid = 1; t_req_valid = 2'b01; dma_req_tag = 4'hA; t_req_tag = 8'h03;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("starve_dma_ready", dma_req_ready, (k % 8) != 7);
      chk("starve_t_ready", t_req_ready, ((k % 8) == 7) ? 2'b01 : 2'b00);
      tick();
    end
    idle(); repeat (4) tick();

    // round robin between threads, response 3 cycles after accept
    do_reset();
    t_req_valid = 2'b11; t_req_tag = {4'd9, 4'd5};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_ready", t_req_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k >= 3) begin
        chk("rr_rsp_valid", rsp_valid, 1);
        chk("rr_rsp_tid", rsp_tid, (k - 3) % 2);
        chk("rr_rsp_tag", rsp_tag, ((k - 3) % 2) ? 4'd9 : 4'd5);
      end
      tick();
    end
    idle(); repeat (4) tick();

    // end-address wrap and misaligned priority
    do_reset();
    t_req_valid = 2'b01; t_req_addr = 64'h0000_0000_FFFF_FFFE; t_req_size = 4'b0010; t_req_tag = 8'h03;
    chk_misaligned_fault_dc2 = 1; chk_access_fault_dc2 = 1; chk_mscause_dc2 = 4'd2;
    @(negedge clk); chk("wrap_ready", t_req_ready, 2'b01);
    tick(); t_req_valid = 0;
    @(negedge clk); chk("wrap_dc1_valid", chk_valid_dc1, 1); chk("wrap_end_dc1", chk_end_addr_dc1, 32'h1);
    tick();
    @(negedge clk); chk("wrap_dc2_valid", chk_valid_dc2, 1); chk("wrap_end_dc2", chk_end_addr_dc2, 32'h1);
    tick();
    @(negedge clk); chk("wrap_rsp_valid", rsp_valid, 1);
    chk("wrap_exc", rsp_exc, 2); chk("wrap_mscause", rsp_mscause, 2);
    tick(); idle(); repeat (3) tick();

    // backpressure: three accepted, fourth held, in-order drain
    do_reset();
    rsp_ready = 0; t_req_valid = 2'b01; t_req_tag = 8'h01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready", t_req_ready, (k < 3) ? 2'b01 : 2'b00);
      tick();
      if (k < 3) t_req_tag = 8'(k + 2);
    end
    rsp_ready = 1; t_req_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_tag", rsp_tag, k + 1);
      tick();
    end
    @(negedge clk); chk("bp_drained", rsp_valid, 0);
    tick();

    // flush of thread 1 with a DMA entry in dc2
    do_reset();
    rsp_ready = 0; t_req_valid = 2'b10; t_req_tag = 8'h10;
    @(negedge clk); chk("fl_acc0", t_req_ready, 2'b10);
    tick(); t_req_valid = 0; dma_req_valid = 1; dma_req_tag = 4'd2;
    @(negedge clk); chk("fl_acc1", dma_req_ready, 1);
    tick(); dma_req_valid = 0; t_req_valid = 2'b10; t_req_tag = 8'h30;
    @(negedge clk); chk("fl_acc2", t_req_ready, 2'b10);
    tick(); t_req_valid = 0; flush = 2'b10;
    @(negedge clk); chk("fl_pre_valid", rsp_valid, 1); chk("fl_pre_tag", rsp_tag, 1);
    tick(); flush = 0; rsp_ready = 1;
    @(negedge clk); chk("fl_dropped", rsp_valid, 0); chk("fl_dma_in_dc2", chk_valid_dc2, 1);
    tick();
    @(negedge clk); chk("fl_dma_rsp", {rsp_valid, rsp_dma, rsp_tag}, {1'b1, 1'b1, 4'd2});
    tick();
    @(negedge clk); chk("fl_empty", {rsp_valid, busy}, 2'b00);
    tick();

    // asynchronous reset with the pipeline full
    do_reset();
    rsp_ready = 0; t_req_valid = 2'b01; t_req_tag = 8'h01;
    repeat (3) tick();
    #2 rst_l = 0;
    #1;
    chk("arst_outputs", {rsp_valid, busy, chk_valid_dc1, chk_valid_dc2}, 4'b0000);
    @(posedge clk); #1 rst_l = 1;
    t_req_valid = 2'b01; rsp_ready = 1; t_req_tag = 8'h07;
    @(negedge clk); chk("arst_accept", t_req_ready, 2'b01);
    tick(); t_req_valid = 0;
    @(negedge clk); chk("arst_lat1", rsp_valid, 0);
    tick();
    @(negedge clk); chk("arst_lat2", rsp_valid, 0);
    tick();
    @(negedge clk); chk("arst_rsp", {rsp_valid, rsp_tag}, {1'b1, 4'd7});
    tick();

    // randomized traffic against the model
    idle();
    for (int c = 0; c < 1500; c++) begin
      t_req_valid = 2'($urandom_range(0, 3));
      t_req_addr = {$urandom, $urandom};
      t_req_size = 4'($urandom);
      t_req_tag = 8'($urandom);
      dma_req_valid = ($urandom_range(0, 9) < 7);
      dma_req_addr = (c % 50 == 0) ? 32'hFFFF_FFFF : $urandom;
      dma_req_size = 2'($urandom);
      dma_req_tag = 4'($urandom);
      flush = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      rsp_ready = ($urandom_range(0, 3) != 0);
      chk_access_fault_dc2 = ($urandom_range(0, 3) == 0);
      chk_misaligned_fault_dc2 = ($urandom_range(0, 3) == 0);
      chk_mscause_dc2 = 4'($urandom);
      tick();
    end
    idle(); repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
